demux1to2_16b: RTL and testbench

DEMUX1TO2_16B -- requirements
Module: demux1to2_16b

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_fifo.sv | 84 ++++++++
 rtl/demux1to2_16b.sv | 74 +++++++
 tb/tb_demux1to2_16b.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and channel-select encodings for the 1-to-2 demultiplexer.
package demux_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 8;

  // in_sel encodings
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// Per-channel output buffer: DEPTH-entry ordered FIFO with a saturating
// count of words handed to the consumer.
module demux_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Delivered-word counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign empty      = (occ == '0);
  assign full       = (occ == OCC_FULL);
  assign head_valid = !empty;
  // A full buffer refuses a push even if it is being drained this cycle.
  assign do_push    = push && !full;
  assign do_pop     = pop_ready && !empty;
  // Storage is not reset; masking the head while empty keeps data X-free
  // and presents 0 after reset.
  assign head_data  = empty ? '0 : mem[rd_ptr];

  // Storage write: data path only, no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and delivered count; reset discards held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
        cnt    <= sat_inc(cnt);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/demux1to2_16b.sv
// 1-to-2 demultiplexer: steers each accepted input word into channel a or b
// according to in_sel; each channel is an independent ready/valid FIFO.
module demux1to2_16b
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clkpos,
  input  logic             rst,
  input  logic             vdd,
  input  logic             vss,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] b_cnt
);

  logic a_full;
  logic b_full;
  logic push_a;
  logic push_b;
  logic unused_supply;

  // Supply pins exist only for netlist compatibility.
  assign unused_supply = vdd ^ vss;

  // Ready reflects only the selected channel's fullness; no pop bypass.
  assign in_ready = !rst && ((in_sel == CH_B) ? !b_full : !a_full);
  assign push_a   = in_valid && in_ready && (in_sel == CH_A);
  assign push_b   = in_valid && in_ready && (in_sel == CH_B);

  demux_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo_a (
    .clk       (clkpos),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_data),
    .pop_ready (a_ready),
    .head_data (a_data),
    .head_valid(a_valid),
    .full      (a_full),
    .cnt       (a_cnt)
  );

  demux_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo_b (
    .clk       (clkpos),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_data),
    .pop_ready (b_ready),
    .head_data (b_data),
    .head_valid(b_valid),
    .full      (b_full),
    .cnt       (b_cnt)
  );

endmodule

// File: tb/tb_demux1to2_16b.sv
// Bench for demux1to2_16b: directed scenarios plus random traffic against a
// queue-based reference of two ordered channels with saturating counters.
module tb_demux1to2_16b;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clkpos;
  logic             rst;
  logic             vdd;
  logic             vss;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [CNT_W-1:0] a_cnt;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] b_cnt;

  int n_checks;
  int n_fail;

  // Reference model state
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  int ca;
  int cb;

  demux1to2_16b #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clkpos  (clkpos),
    .rst     (rst),
    .vdd     (vdd),
    .vss     (vss),
    .in_data (in_data),
    .in_sel  (in_sel),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_data  (a_data),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_cnt   (a_cnt),
    .b_data  (b_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_cnt   (b_cnt)
  );

  initial clkpos = 1'b0;
  always #5 clkpos = ~clkpos;

  // Expected in_ready from the model (before the edge).
  function automatic logic exp_ready();
    if (rst) return 1'b0;
    return in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
  endfunction

  // Advance the model by the transfers of the coming edge, then step the DUT.
  task automatic tick();
    logic acc;
    logic pa;
    logic pb;
    if (rst) begin
      qa.delete();
      qb.delete();
      ca = 0;
      cb = 0;
    end else begin
      acc = in_valid && (in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
      pa  = a_ready && (qa.size() > 0);
      pb  = b_ready && (qb.size() > 0);
      if (pa) begin
        void'(qa.pop_front());
        if (ca < CMAX) ca++;
      end
      if (pb) begin
        void'(qb.pop_front());
        if (cb < CMAX) cb++;
      end
      if (acc) begin
        if (in_sel) qb.push_back(in_data);
        else        qa.push_back(in_data);
      end
    end
    @(posedge clkpos);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 16'hFFFF;
    a_ready = 1'b0; b_ready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_checks++;
    if ({a_valid, b_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid got=%b%b exp=00", a_valid, b_valid); end
    n_checks++;
    if (a_cnt !== '0 || b_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
    n_checks++;
    if (a_data !== '0 || b_data !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", a_data, b_data); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1234; a_ready = 1'b0; b_ready = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (a_valid !== 1'b1 || a_data !== 16'h1234) begin n_fail++; $display("FAIL single_a got v=%b d=%h exp v=1 d=1234", a_valid, a_data); end
    n_checks++;
    if (b_valid !== 1'b0 || a_cnt !== 8'd0) begin n_fail++; $display("FAIL single_side got b_valid=%b a_cnt=%0d exp 0/0", b_valid, a_cnt); end
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    n_checks++;
    if (a_valid !== 1'b0 || a_cnt !== 8'(ca)) begin n_fail++; $display("FAIL single_drain got v=%b cnt=%0d exp v=0 cnt=%0d", a_valid, a_cnt, ca); end
  endtask

  task automatic test_fill_b();
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'hAAAA; b_ready = 1'b0;
    tick();
    in_data = 16'hBBBB;
    tick();
    in_valid = 1'b0; in_sel = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullb_ready_sel1 got=%b exp=0", in_ready); end
    in_sel = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullb_ready_sel0 got=%b exp=1", in_ready); end
    b_ready = 1'b1;
    n_checks++;
    if (b_valid !== 1'b1 || b_data !== 16'hAAAA) begin n_fail++; $display("FAIL fullb_first got v=%b d=%h exp v=1 d=aaaa", b_valid, b_data); end
    tick();
    n_checks++;
    if (b_valid !== 1'b1 || b_data !== 16'hBBBB) begin n_fail++; $display("FAIL fullb_second got v=%b d=%h exp v=1 d=bbbb", b_valid, b_data); end
    tick();
    b_ready = 1'b0;
    n_checks++;
    if (b_valid !== 1'b0 || b_cnt !== 8'd2) begin n_fail++; $display("FAIL fullb_done got v=%b cnt=%0d exp v=0 cnt=2", b_valid, b_cnt); end
  endtask

  task automatic test_push_pop_same();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 16'h1111; a_ready = 1'b0;
    tick();
    in_data = 16'h5555; a_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (a_valid !== 1'b1 || a_data !== 16'h5555) begin n_fail++; $display("FAIL pushpop_head got v=%b d=%h exp v=1 d=5555", a_valid, a_data); end
    tick();
    a_ready = 1'b0;
    n_checks++;
    if (a_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop_occ got v=%b exp=0", a_valid); end
  endtask

  task automatic test_full_reject();
    in_valid = 1'b1; in_sel = 1'b0; a_ready = 1'b0;
    in_data = 16'h0101;
    tick();
    in_data = 16'h0202;
    tick();
    in_data = 16'h7777; a_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullrej_ready got=%b exp=0", in_ready); end
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullrej_next_ready got=%b exp=1", in_ready); end
    n_checks++;
    if (a_data !== 16'h0202) begin n_fail++; $display("FAIL fullrej_head got=%h exp=0202", a_data); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (a_valid !== 1'b1 || a_data !== 16'h7777) begin n_fail++; $display("FAIL fullrej_accepted got v=%b d=%h exp v=1 d=7777", a_valid, a_data); end
    tick();
    a_ready = 1'b0;
    n_checks++;
    if (a_valid !== 1'b0 || a_cnt !== 8'(ca)) begin n_fail++; $display("FAIL fullrej_drain got v=%b cnt=%0d exp v=0 cnt=%0d", a_valid, a_cnt, ca); end
  endtask

  task automatic test_saturate();
    logic [WIDTH-1:0] exp_d;
    a_ready = 1'b0; b_ready = 1'b1; in_sel = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = WIDTH'($urandom);
      #1;
      n_checks++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL sat_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready()); end
      tick();
      exp_d = (qb.size() > 0) ? qb[0] : '0;
      n_checks++;
      if (b_valid !== (qb.size() > 0) || (b_valid && b_data !== exp_d)) begin
        n_fail++; $display("FAIL sat_data[%0d] got v=%b d=%h exp v=%b d=%h", i, b_valid, b_data, qb.size() > 0, exp_d);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    b_ready = 1'b0;
    n_checks++;
    if (b_cnt !== 8'd255 || b_cnt !== 8'(cb)) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=255 model=%0d", b_cnt, cb); end
    n_checks++;
    if (b_valid !== 1'b0) begin n_fail++; $display("FAIL sat_empty got v=%b exp=0", b_valid); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 49) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_sel   = $urandom_range(0, 1) != 0;
      in_data  = WIDTH'($urandom);
      a_ready  = $urandom_range(0, 2) == 0;
      b_ready  = $urandom_range(0, 2) != 0;
      #1;
      n_checks++;
      if (in_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, exp_ready()); end
      tick();
      ea = (qa.size() > 0) ? qa[0] : '0;
      eb = (qb.size() > 0) ? qb[0] : '0;
      n_checks++;
      if (a_valid !== (qa.size() > 0) || (a_valid && a_data !== ea) || a_cnt !== 8'(ca)) begin
        n_fail++; $display("FAIL rnd_a[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d", i, a_valid, a_data, a_cnt, qa.size() > 0, ea, ca);
      end
      n_checks++;
      if (b_valid !== (qb.size() > 0) || (b_valid && b_data !== eb) || b_cnt !== 8'(cb)) begin
        n_fail++; $display("FAIL rnd_b[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d", i, b_valid, b_data, b_cnt, qb.size() > 0, eb, cb);
      end
    end
    rst = 1'b0; in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_full();
    rst = 1'b1;
    tick();
    rst = 1'b0; a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel  = i[0];
      in_data = 16'hC000 + 16'(i);
      tick();
    end
    n_checks++;
    if ({a_valid, b_valid} !== 2'b11) begin n_fail++; $display("FAIL rstfull_pre got=%b%b exp=11", a_valid, b_valid); end
    rst = 1'b1; a_ready = 1'b1; b_ready = 1'b1; in_sel = 1'b0; in_data = 16'hDEAD;
    tick();
    n_checks++;
    if ({a_valid, b_valid} !== 2'b00 || a_cnt !== '0 || b_cnt !== '0) begin
      n_fail++; $display("FAIL rstfull_post got v=%b%b c=%0d/%0d exp v=00 c=0/0", a_valid, b_valid, a_cnt, b_cnt);
    end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({a_valid, b_valid} !== 2'b00 || a_data !== '0 || b_data !== '0) begin
      n_fail++; $display("FAIL rstfull_stale got v=%b%b d=%h/%h exp v=00 d=0/0", a_valid, b_valid, a_data, b_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ca = 0;
    cb = 0;
    vdd = 1'b1; vss = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    a_ready = 1'b0; b_ready = 1'b0;
    test_reset();
    test_single_push();
    test_fill_b();
    test_push_pop_same();
    test_full_reject();
    test_saturate();
    test_random();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
